seg7_scan_capture: RTL and testbench

- Receive side of the 4-digit multiplexed seven-segment bus that the display driver produces.
- Samples the active-low anode select and active-low segment lines, and recovers the four displayed BCD values (score hundreds/tens/units, lives).
- Used as an on-board loopback monitor and as a self-check for the scoring path.
- Publishes a complete frame only after all four digit slots have been captured.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_decode.sv | 28 ++
 rtl/seg7_scan_capture.sv | 210 +++++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan capture path and its decoder.
package seg7_pkg;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] ANODE_BLANK = 4'b1111;

  // Active-low g..a patterns, dp excluded
  localparam logic [6:0] SEG7_CODE_0 = 7'h40;
  localparam logic [6:0] SEG7_CODE_1 = 7'h79;
  localparam logic [6:0] SEG7_CODE_2 = 7'h24;
  localparam logic [6:0] SEG7_CODE_3 = 7'h30;
  localparam logic [6:0] SEG7_CODE_4 = 7'h19;
  localparam logic [6:0] SEG7_CODE_5 = 7'h12;
  localparam logic [6:0] SEG7_CODE_6 = 7'h02;
  localparam logic [6:0] SEG7_CODE_7 = 7'h78;
  localparam logic [6:0] SEG7_CODE_8 = 7'h00;
  localparam logic [6:0] SEG7_CODE_9 = 7'h10;

  typedef logic [1:0] slot_t;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low seven-segment to BCD decoder; valid drops for any pattern outside 0..9.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0]       seg,
  output logic [BCD_W-1:0] bcd,
  output logic             valid
);

  always_comb begin
    bcd   = '0;
    valid = 1'b1;
    case (seg)
      SEG7_CODE_0: bcd = 4'd0;
      SEG7_CODE_1: bcd = 4'd1;
      SEG7_CODE_2: bcd = 4'd2;
      SEG7_CODE_3: bcd = 4'd3;
      SEG7_CODE_4: bcd = 4'd4;
      SEG7_CODE_5: bcd = 4'd5;
      SEG7_CODE_6: bcd = 4'd6;
      SEG7_CODE_7: bcd = 4'd7;
      SEG7_CODE_8: bcd = 4'd8;
      SEG7_CODE_9: bcd = 4'd9;
      default:     valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers the four BCD digits from a multiplexed 7-seg bus and publishes them as a complete frame.
// Optional SEG7_SCAN_CAPTURE_DP_EN adds per-slot decimal point capture on dp_out.
//
// state  | meaning
// BLANK  | no digit selected (blank or illegal anode)
// SETTLE | counting consecutive identical slot samples
// LOCKED | digit accepted, waiting for the sample to change
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] digit_anode,
  input  logic [7:0] segment,
  output logic [3:0] fenshu2,
  output logic [3:0] fenshu1,
  output logic [3:0] fenshu0,
  output logic [3:0] shengming,
`ifdef SEG7_SCAN_CAPTURE_DP_EN
  output logic [3:0] dp_out,
`endif
  output logic       frame_valid,
  output logic       seg_err,
  output logic       anode_err
);

`ifdef SEG7_SCAN_CAPTURE_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
  logic unused_dp;
  assign unused_dp = segment[7];
`endif

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYC);

  logic [3:0]       an_s;
  logic [SEG_W-1:0] seg_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign an_s  = digit_anode;
      assign seg_s = segment[SEG_W-1:0];
    end else begin : g_sync
      logic [3:0]       an_q  [SYNC_STAGES];
      logic [SEG_W-1:0] seg_q [SYNC_STAGES];
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            an_q[i]  <= ANODE_BLANK;
            seg_q[i] <= '1;
          end
        end else begin
          an_q[0]  <= digit_anode;
          seg_q[0] <= segment[SEG_W-1:0];
          for (int i = 1; i < SYNC_STAGES; i++) begin
            an_q[i]  <= an_q[i-1];
            seg_q[i] <= seg_q[i-1];
          end
        end
      end
      assign an_s  = an_q[SYNC_STAGES-1];
      assign seg_s = seg_q[SYNC_STAGES-1];
    end
  endgenerate

  // Slot 0 is the hundreds digit (anode bit3) through slot 3 = lives (anode bit0)
  logic  slot_ok, illegal_s;
  slot_t slot_s;

  always_comb begin
    slot_ok   = 1'b1;
    illegal_s = 1'b0;
    slot_s    = 2'd0;
    case (an_s)
      4'b0111:     slot_s = 2'd0;
      4'b1011:     slot_s = 2'd1;
      4'b1101:     slot_s = 2'd2;
      4'b1110:     slot_s = 2'd3;
      ANODE_BLANK: slot_ok = 1'b0;
      default: begin
        slot_ok   = 1'b0;
        illegal_s = 1'b1;
      end
    endcase
  end

  logic [BCD_W-1:0] dec_bcd;
  logic             dec_valid;

  seg7_decode u_decode (
    .seg   (seg_s[6:0]),
    .bcd   (dec_bcd),
    .valid (dec_valid)
  );

  logic [SEG_W+1:0] key_s, key_q;
  assign key_s = {slot_s, seg_s};

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       cap;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    case (state)
      BLANK: begin
        if (slot_ok) begin
          state_n = SETTLE;
          cnt_n   = 4'd1;
        end
      end
      SETTLE: begin
        if (!slot_ok) begin
          state_n = BLANK;
          cnt_n   = 4'd0;
        end else if (key_s == key_q) begin
          cnt_n = cnt + 4'd1;
        end else begin
          cnt_n = 4'd1;
        end
      end
      LOCKED: begin
        if (!slot_ok) begin
          state_n = BLANK;
          cnt_n   = 4'd0;
        end else if (key_s != key_q) begin
          state_n = SETTLE;
          cnt_n   = 4'd1;
        end
      end
      default: begin
        state_n = BLANK;
        cnt_n   = 4'd0;
      end
    endcase
    if (state_n == SETTLE && cnt_n == STABLE_C) begin
      cap     = 1'b1;
      state_n = LOCKED;
    end
  end

  logic illegal_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= BLANK;
      cnt       <= 4'd0;
      key_q     <= '0;
      illegal_q <= 1'b0;
      seg_err   <= 1'b0;
      anode_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      key_q     <= key_s;
      illegal_q <= illegal_s;
      seg_err   <= cap & ~dec_valid;
      anode_err <= illegal_s & ~illegal_q;
    end
  end

  logic [BCD_W-1:0]      shadow [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] mask;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
  logic [NUM_DIGITS-1:0] shadow_dp;
`endif

  // A full mask publishes on the following edge; a capture landing on that edge is dropped
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
      mask        <= '0;
      frame_valid <= 1'b0;
      fenshu2     <= '0;
      fenshu1     <= '0;
      fenshu0     <= '0;
      shengming   <= '0;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
      shadow_dp   <= '0;
      dp_out      <= '0;
`endif
    end else if (&mask) begin
      mask        <= '0;
      frame_valid <= 1'b1;
      fenshu2     <= shadow[0];
      fenshu1     <= shadow[1];
      fenshu0     <= shadow[2];
      shengming   <= shadow[3];
`ifdef SEG7_SCAN_CAPTURE_DP_EN
      dp_out      <= {~shadow_dp[0], ~shadow_dp[1], ~shadow_dp[2], ~shadow_dp[3]};
`endif
    end else begin
      frame_valid <= 1'b0;
      if (cap && dec_valid) begin
        shadow[slot_s] <= dec_bcd;
        mask[slot_s]   <= 1'b1;
`ifdef SEG7_SCAN_CAPTURE_DP_EN
        shadow_dp[slot_s] <= seg_s[7];
`endif
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: a digit-level model predicts frames and error pulses.
module tb_seg7_scan_capture;

  localparam int STABLE = 2;
  localparam int SYNC  = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] digit_anode = 4'b1111;
  logic [7:0] segment = 8'hFF;
  logic [3:0] fenshu2, fenshu1, fenshu0, shengming;
  logic       frame_valid, seg_err, anode_err;

  seg7_scan_capture #(.STABLE_CYC(STABLE), .SYNC_STAGES(SYNC)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .digit_anode (digit_anode),
    .segment     (segment),
    .fenshu2     (fenshu2),
    .fenshu1     (fenshu1),
    .fenshu0     (fenshu0),
    .shengming   (shengming),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .anode_err   (anode_err)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference digit model, indexed by anode bit (3 = hundreds .. 0 = lives)
  logic [6:0]  codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0]  m_shadow [4];
  logic [3:0]  m_mask;
  logic [15:0] exp_q [$];
  logic [15:0] exp_cur = 16'h0;
  int          exp_seg_err = 0, exp_an_err = 0;
  int          seen_seg_err = 0, seen_an_err = 0;

  function automatic int lookup(input logic [6:0] c);
    for (int d = 0; d < 10; d++) if (codes[d] == c) return d;
    return -1;
  endfunction

  task automatic model_event(input logic [3:0] an, input logic [6:0] c, input int n);
    int zeros, bitpos, d;
    zeros = $countones(~an);
    if (zeros >= 2) begin
      exp_an_err++;
    end else if (zeros == 1 && n >= STABLE) begin
      bitpos = 0;
      for (int b = 0; b < 4; b++) if (!an[b]) bitpos = b;
      d = lookup(c);
      if (d < 0) exp_seg_err++;
      else begin
        m_shadow[bitpos] = 4'(d);
        m_mask[bitpos]   = 1'b1;
        if (m_mask == 4'hF) begin
          exp_q.push_back({m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]});
          m_mask = 4'h0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Show one pattern for n cycles (dp toggling freely), then m blank cycles
  task automatic show(input logic [3:0] an, input logic [6:0] c, input int n, input int m);
    model_event(an, c, n);
    for (int i = 0; i < n; i++) begin
      digit_anode = an;
      segment     = {1'($urandom_range(0, 1)), c};
      tick();
    end
    for (int i = 0; i < m; i++) begin
      digit_anode = 4'b1111;
      segment     = 8'($urandom);
      tick();
    end
  endtask

  task automatic do_reset();
    show(4'b1111, 7'h7F, 0, 8);
    exp_cur = 16'h0;
    RST     = 1'b1;
    for (int b = 0; b < 4; b++) m_shadow[b] = 4'h0;
    m_mask = 4'h0;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  initial begin : monitor
    logic [15:0] got;
    forever begin
      @(negedge CLK);
      got = {fenshu2, fenshu1, fenshu0, shengming};
      n_chk++;
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_unexpected got=%h required=none", got);
        end else begin
          exp_cur = exp_q.pop_front();
          if (got !== exp_cur) begin
            n_fail++;
            $display("FAIL frame_value got=%h required=%h", got, exp_cur);
          end
        end
      end else if (got !== exp_cur) begin
        n_fail++;
        $display("FAIL output_hold got=%h required=%h", got, exp_cur);
      end
      n_chk++;
      if (seg_err === 1'b1 && anode_err === 1'b1) begin
        n_fail++;
        $display("FAIL err_overlap seg_err=1 anode_err=1 required=not both");
      end
      if (seg_err) seen_seg_err++;
      if (anode_err) seen_an_err++;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout after 2ms, summary not reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] an;
    logic [6:0] c;
    int         b;
    for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
    m_mask = 4'h0;
    tick();
    tick();
    RST = 1'b0;
    @(negedge CLK);
    n_chk++;
    if ({fenshu2, fenshu1, fenshu0, shengming, frame_valid, seg_err, anode_err} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_state got=%h required=0",
               {fenshu2, fenshu1, fenshu0, shengming, frame_valid, seg_err, anode_err});
    end
    tick();

    // nominal frame 0,1,2,4
    show(4'b0111, 7'h40, 4, 8);
    show(4'b1011, 7'h79, 4, 8);
    show(4'b1101, 7'h24, 4, 8);
    show(4'b1110, 7'h19, 4, 8);
    // glitch rejection then a held 3 on tens
    show(4'b1011, 7'h30, 1, 4);
    show(4'b0111, 7'h12, 3, 4);
    show(4'b1101, 7'h02, 3, 4);
    show(4'b1110, 7'h78, 3, 4);
    show(4'b1011, 7'h30, 2, 6);
    // invalid pattern on units, then frame completes once units is valid
    show(4'b1101, 7'h7F, 4, 4);
    show(4'b0111, 7'h00, 3, 4);
    show(4'b1011, 7'h10, 3, 4);
    show(4'b1110, 7'h79, 3, 4);
    show(4'b1101, 7'h19, 3, 6);
    // illegal anode
    show(4'b0011, 7'h40, 3, 4);
    // re-capture of lives: 7 then 9
    show(4'b1110, 7'h78, 3, 3);
    show(4'b1110, 7'h10, 3, 3);
    show(4'b0111, 7'h79, 3, 3);
    show(4'b1011, 7'h24, 3, 3);
    show(4'b1101, 7'h30, 3, 6);
    // reset mid-frame
    show(4'b0111, 7'h19, 3, 3);
    show(4'b1011, 7'h12, 3, 3);
    show(4'b1101, 7'h02, 3, 3);
    do_reset();
    show(4'b0111, 7'h78, 3, 3);
    show(4'b1011, 7'h00, 3, 3);
    show(4'b1101, 7'h10, 3, 3);
    show(4'b1110, 7'h40, 3, 6);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      b  = $urandom_range(0, 3);
      an = 4'b1111;
      an[b] = 1'b0;
      c  = codes[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) c = 7'($urandom);
      if ($urandom_range(0, 14) == 0) begin
        do an = 4'($urandom); while ($countones(~an) < 2);
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      else show(an, c, $urandom_range(1, 4), $urandom_range(1, 5));
    end

    show(4'b1111, 7'h7F, 0, 20);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL frames_missing got=%0d_left required=0", exp_q.size());
    end
    n_chk++;
    if (seen_seg_err != exp_seg_err) begin
      n_fail++;
      $display("FAIL seg_err_count got=%0d required=%0d", seen_seg_err, exp_seg_err);
    end
    n_chk++;
    if (seen_an_err != exp_an_err) begin
      n_fail++;
      $display("FAIL anode_err_count got=%0d required=%0d", seen_an_err, exp_an_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
